// File: rtl/multicycle_rv_core.sv
// Multi-cycle RV32I-subset core: FETCH/DECODE/EXECUTE/WRITE with one instruction in flight,
// halting on ECALL, illegal encodings or a taken branch to a misaligned target.
module multicycle_rv_core #(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 32,
  parameter logic [XLEN-1:0] PC_RESET = {XLEN{1'b0}},
  parameter int              CNT_W    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    imem_req,
  output logic [XLEN-1:0]         imem_addr,
  input  logic                    imem_rvalid,
  input  logic [31:0]             imem_rdata,
  input  logic [$clog2(NREG)-1:0] dbg_addr,
  output logic [XLEN-1:0]         dbg_data,
  output logic                    halted,
  output logic [1:0]              halt_cause,
  output logic [CNT_W-1:0]        retired
);
  localparam int AW = $clog2(NREG);
  localparam int SW = $clog2(XLEN);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  logic [2:0]      state;
  logic [XLEN-1:0] pc, op_a, op_b, imm, result, target, alu;
  logic [XLEN-1:0] rs1_val, rs2_val, imm_i, imm_b;
  logic [31:0]     instr;
  logic [1:0]      pend_cause, dec_cause;
  logic            br_taken, taken, legal;
  logic [XLEN-1:0] regs [NREG];

  logic [6:0] opcode, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic       is_r, is_i, is_b, is_ecall;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) r[i] = v[(i < 32) ? i : 31];
    return r;
  endfunction

  function automatic logic reg_ok(input logic [4:0] idx);
    return ({27'd0, idx} < 32'(NREG));
  endfunction

  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign f3       = instr[14:12];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign f7       = instr[31:25];
  assign is_r     = (opcode == 7'b0110011);
  assign is_i     = (opcode == 7'b0010011);
  assign is_b     = (opcode == 7'b1100011);
  assign is_ecall = (instr == 32'h0000_0073);

  assign rs1_val = regs[rs1[AW-1:0]];
  assign rs2_val = regs[rs2[AW-1:0]];
  assign imm_i   = sext32({{20{instr[31]}}, instr[31:20]});
  assign imm_b   = sext32({{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});

  assign imem_req  = (state == S_FETCH) && !rst;
  assign imem_addr = pc;
  // Debug port reads the array directly, so a same-cycle write is seen one cycle later
  assign dbg_data  = ((dbg_addr == {AW{1'b0}}) || (32'(dbg_addr) >= 32'(NREG))) ?
                     {XLEN{1'b0}} : regs[dbg_addr];

  // Legality and halt-cause decode of the captured instruction word
  always_comb begin
    legal     = 1'b0;
    dec_cause = 2'd0;
    case (opcode)
      7'b0110011: legal = ((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))))
                          && reg_ok(rd) && reg_ok(rs1) && reg_ok(rs2);
      7'b0010011: legal = reg_ok(rd) && reg_ok(rs1) &&
                          ((f3 == 3'b001) ? (f7 == 7'h00) :
                           (f3 == 3'b101) ? ((f7 == 7'h00) || (f7 == 7'h20)) : 1'b1);
      7'b1100011: legal = ((f3 == 3'b000) || (f3 == 3'b001)) && reg_ok(rs1) && reg_ok(rs2);
      default:    legal = 1'b0;
    endcase
    if (is_ecall)    dec_cause = 2'd1;
    else if (!legal) dec_cause = 2'd2;
    else             dec_cause = 2'd0;
  end

  // ALU and branch condition on the registered operands
  always_comb begin
    alu = {XLEN{1'b0}};
    case (f3)
      3'b000:  alu = (is_r && f7[5]) ? (op_a - op_b) : (op_a + op_b);
      3'b001:  alu = op_a << op_b[SW-1:0];
      3'b010:  alu = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      3'b011:  alu = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      3'b100:  alu = op_a ^ op_b;
      3'b101:  alu = f7[5] ? XLEN'($signed(op_a) >>> op_b[SW-1:0]) : (op_a >> op_b[SW-1:0]);
      3'b110:  alu = op_a | op_b;
      3'b111:  alu = op_a & op_b;
      default: alu = {XLEN{1'b0}};
    endcase
    if (f3[0]) taken = is_b && (op_a != op_b);
    else       taken = is_b && (op_a == op_b);
  end

  // Main FSM, register file, PC, halt status and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= PC_RESET;
      instr      <= 32'h0000_0000;
      op_a       <= {XLEN{1'b0}};
      op_b       <= {XLEN{1'b0}};
      imm        <= {XLEN{1'b0}};
      result     <= {XLEN{1'b0}};
      target     <= {XLEN{1'b0}};
      br_taken   <= 1'b0;
      pend_cause <= 2'd0;
      halted     <= 1'b0;
      halt_cause <= 2'd0;
      retired    <= {CNT_W{1'b0}};
      for (int i = 0; i < NREG; i++) regs[i] <= {XLEN{1'b0}};
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_rvalid) begin
            instr <= imem_rdata;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          op_a       <= rs1_val;
          op_b       <= is_i ? imm_i : rs2_val;
          imm        <= is_b ? imm_b : imm_i;
          pend_cause <= dec_cause;
          state      <= S_EXEC;
        end
        S_EXEC: begin
          result   <= alu;
          br_taken <= taken;
          target   <= pc + imm;
          // A misaligned target only faults when the branch is actually taken
          if ((pend_cause == 2'd0) && taken && ((pc[1:0] + imm[1:0]) != 2'b00))
            pend_cause <= 2'd3;
          state <= S_WRITE;
        end
        S_WRITE: begin
          if (pend_cause != 2'd0) begin
            halted     <= 1'b1;
            halt_cause <= pend_cause;
            state      <= S_HALT;
          end else begin
            if ((is_r || is_i) && (rd != 5'd0)) regs[rd[AW-1:0]] <= result;
            pc      <= br_taken ? target : (pc + XLEN'(4));
            retired <= retired + CNT_W'(1);
            state   <= S_FETCH;
          end
        end
        S_HALT: state <= S_HALT;
        default: begin
          halted     <= 1'b1;
          halt_cause <= 2'd2;
          state      <= S_HALT;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_rv_core.sv
// Bench for multicycle_rv_core: instruction-memory responder, fetch-address scoreboard
// with a decoupled monitor, and directed programs with hand-computed results.
module tb_multicycle_rv_core;
  logic        clk, rst;
  logic        imem_req, imem_rvalid, halted;
  logic [31:0] imem_addr, imem_rdata, dbg_data, retired;
  logic [4:0]  dbg_addr;
  logic [1:0]  halt_cause;

  logic        rst_b, imem_req_b, imem_rvalid_b, halted_b;
  logic [31:0] imem_addr_b, imem_rdata_b, dbg_data_b, retired_b;
  logic [3:0]  dbg_addr_b;
  logic [1:0]  halt_cause_b;

  logic [31:0] mem   [64];
  logic [31:0] mem_b [16];
  logic [31:0] exp_q [$];
  logic [31:0] exp_reg [32];
  int          wait_cycles, wcnt, checks, failures;
  bit          spurious, prev_req;
  logic [31:0] prev_addr;

  multicycle_rv_core #(.XLEN(32), .NREG(32), .PC_RESET(32'h0), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .halted(halted), .halt_cause(halt_cause), .retired(retired));

  multicycle_rv_core #(.XLEN(32), .NREG(16), .PC_RESET(32'h40), .CNT_W(32)) u_dut16 (
    .clk(clk), .rst(rst_b), .imem_req(imem_req_b), .imem_addr(imem_addr_b),
    .imem_rvalid(imem_rvalid_b), .imem_rdata(imem_rdata_b), .dbg_addr(dbg_addr_b),
    .dbg_data(dbg_data_b), .halted(halted_b), .halt_cause(halt_cause_b), .retired(retired_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_reg(input string name, input int r, input logic [31:0] exp);
    dbg_addr = 5'(r);
    #1;
    check(name, dbg_data, exp);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0073;
  endtask

  task automatic push_fetch(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(32'(4 * i));
  endtask

  task automatic reset_assert();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_release();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_halt(input int budget, input bit sel_b, input string name);
    int n = 0;
    while (n < budget && !(sel_b ? halted_b : halted)) begin
      @(negedge clk);
      n++;
    end
    check(name, sel_b ? halted_b : halted, 64'd1);
  endtask

  task automatic check_quiet(input string name);
    int hi = 0;
    repeat (20) begin
      @(negedge clk);
      #3;
      if (imem_req) hi++;
    end
    check(name, 64'(hi), 64'd0);
  endtask

  // Memory responder for the main core: optional wait states and spurious RVALID
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    wcnt        = 0;
    forever begin
      @(negedge clk);
      #1;
      if (imem_req) begin
        if (wcnt >= wait_cycles) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem[imem_addr[7:2]];
          wcnt        = 0;
        end else begin
          imem_rvalid = 1'b0;
          imem_rdata  = 32'hDEAD_BEEF;
          wcnt++;
        end
      end else begin
        imem_rvalid = spurious;
        imem_rdata  = 32'hFFFF_FFFF;
        wcnt        = 0;
      end
    end
  end

  // Zero-wait responder for the NREG=16 core (code based at 0x40)
  initial begin
    logic [31:0] off;
    imem_rvalid_b = 1'b0;
    imem_rdata_b  = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      off           = imem_addr_b - 32'h40;
      imem_rvalid_b = imem_req_b;
      imem_rdata_b  = mem_b[off[5:2]];
    end
  end

  // Monitor: checks every accepted fetch against the scoreboard and address stability
  initial begin
    prev_req  = 1'b0;
    prev_addr = 32'h0;
    forever begin
      @(negedge clk);
      #2;
      if (imem_req && prev_req) check("addr_stable", imem_addr, prev_addr);
      if (imem_req && imem_rvalid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL fetch_unexpected actual=%0h expected=none", imem_addr);
        end else begin
          check("fetch_addr", imem_addr, exp_q.pop_front());
        end
      end
      prev_req  = imem_req;
      prev_addr = imem_addr;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    checks = 0; failures = 0; wait_cycles = 0; spurious = 1'b0;
    rst = 1'b1; rst_b = 1'b1; dbg_addr = 5'd0; dbg_addr_b = 4'd0;
    for (int i = 0; i < 16; i++) mem_b[i] = 32'h0000_0073;

    // Test 1: reset state, then three ALU instructions at 4 cycles each
    clear_mem();
    mem[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1);
    mem[1] = enc_i(12'hFFD, 5'd0, 3'b000, 5'd2);
    mem[2] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
    reset_assert();
    check("rst_req", imem_req, 64'd0);
    check("rst_addr", imem_addr, 64'd0);
    check("rst_halted", halted, 64'd0);
    check("rst_cause", halt_cause, 64'd0);
    check("rst_retired", retired, 64'd0);
    reset_release();
    push_fetch(4);
    repeat (11) @(negedge clk);
    check("t1_retired_c11", retired, 64'd2);
    @(negedge clk);
    check("t1_retired_c12", retired, 64'd3);
    check_reg("t1_x3", 3, 32'd2);
    wait_halt(20, 1'b0, "t1_halt");
    check("t1_cause", halt_cause, 64'd1);
    check("t1_retired_end", retired, 64'd3);
    check("t1_q_empty", 64'(exp_q.size()), 64'd0);

    // Test 2: three wait states per fetch plus spurious RVALID while idle
    wait_cycles = 3;
    spurious    = 1'b1;
    reset_assert();
    reset_release();
    push_fetch(4);
    repeat (20) @(negedge clk);
    check("t2_retired_c20", retired, 64'd2);
    @(negedge clk);
    check("t2_retired_c21", retired, 64'd3);
    check_reg("t2_x3", 3, 32'd2);
    check_reg("t2_x2", 2, 32'hFFFF_FFFD);
    wait_halt(40, 1'b0, "t2_halt");
    check("t2_q_empty", 64'(exp_q.size()), 64'd0);
    wait_cycles = 0;
    spurious    = 1'b0;

    // Test 3: x0 stays zero, increment wraps
    clear_mem();
    mem[0] = enc_i(12'd7, 5'd0, 3'b000, 5'd0);
    mem[1] = enc_i(12'hFFF, 5'd0, 3'b000, 5'd1);
    mem[2] = enc_i(12'd1, 5'd1, 3'b000, 5'd1);
    mem[3] = enc_i(12'd0, 5'd0, 3'b000, 5'd5);
    reset_assert();
    reset_release();
    push_fetch(5);
    wait_halt(40, 1'b0, "t3_halt");
    check_reg("t3_x0", 0, 32'd0);
    check_reg("t3_x1", 1, 32'd0);
    check_reg("t3_x5", 5, 32'd0);
    check("t3_retired", retired, 64'd4);

    // Test 3b: every ALU operation
    clear_mem();
    mem[0]  = enc_i(12'hFF8, 5'd0, 3'b000, 5'd1);
    mem[1]  = enc_i(12'd3, 5'd0, 3'b000, 5'd2);
    mem[2]  = enc_i(12'd33, 5'd0, 3'b000, 5'd21);
    mem[3]  = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd3);
    mem[4]  = enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd4);
    mem[5]  = enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd5);
    mem[6]  = enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd6);
    mem[7]  = enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd7);
    mem[8]  = enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd8);
    mem[9]  = enc_r(7'h00, 5'd2, 5'd2, 3'b001, 5'd9);
    mem[10] = enc_r(7'h00, 5'd2, 5'd1, 3'b101, 5'd10);
    mem[11] = enc_r(7'h20, 5'd2, 5'd1, 3'b101, 5'd11);
    mem[12] = enc_i(12'h0F0, 5'd1, 3'b111, 5'd12);
    mem[13] = enc_i(12'hFF0, 5'd2, 3'b110, 5'd13);
    mem[14] = enc_i(12'd5, 5'd2, 3'b100, 5'd14);
    mem[15] = enc_i(12'hFF9, 5'd1, 3'b010, 5'd15);
    mem[16] = enc_i(12'hFFF, 5'd2, 3'b011, 5'd16);
    mem[17] = enc_i(12'h01E, 5'd2, 3'b001, 5'd17);
    mem[18] = enc_i(12'h01C, 5'd1, 3'b101, 5'd18);
    mem[19] = enc_i(12'h401, 5'd1, 3'b101, 5'd19);
    mem[20] = enc_r(7'h00, 5'd21, 5'd2, 3'b001, 5'd20);
    for (int i = 0; i < 32; i++) exp_reg[i] = 32'h0;
    exp_reg[1]  = 32'hFFFF_FFF8; exp_reg[2]  = 32'd3;        exp_reg[21] = 32'd33;
    exp_reg[3]  = 32'hFFFF_FFF5; exp_reg[4]  = 32'h0;        exp_reg[5]  = 32'hFFFF_FFFB;
    exp_reg[6]  = 32'hFFFF_FFFB; exp_reg[7]  = 32'd1;        exp_reg[8]  = 32'd0;
    exp_reg[9]  = 32'd24;        exp_reg[10] = 32'h1FFF_FFFF; exp_reg[11] = 32'hFFFF_FFFF;
    exp_reg[12] = 32'h0000_00F0; exp_reg[13] = 32'hFFFF_FFF3; exp_reg[14] = 32'd6;
    exp_reg[15] = 32'd1;         exp_reg[16] = 32'd1;        exp_reg[17] = 32'hC000_0000;
    exp_reg[18] = 32'h0000_000F; exp_reg[19] = 32'hFFFF_FFFC; exp_reg[20] = 32'd6;
    reset_assert();
    reset_release();
    push_fetch(22);
    wait_halt(200, 1'b0, "alu_halt");
    for (int r = 0; r < 22; r++) check_reg($sformatf("alu_x%0d", r), r, exp_reg[r]);
    check("alu_retired", retired, 64'd21);

    // Test 4: BEQ/BNE taken and not taken, then taken branch to misaligned target
    clear_mem();
    mem[0] = enc_i(12'd4, 5'd0, 3'b000, 5'd1);
    mem[1] = enc_i(12'd4, 5'd0, 3'b000, 5'd2);
    mem[2] = enc_b(13'd8, 5'd2, 5'd1, 3'b000);
    mem[3] = enc_i(12'd1, 5'd0, 3'b000, 5'd5);
    mem[4] = enc_b(13'd8, 5'd2, 5'd1, 3'b001);
    mem[5] = enc_i(12'd2, 5'd0, 3'b000, 5'd6);
    mem[6] = enc_b(13'd8, 5'd6, 5'd1, 3'b001);
    mem[7] = enc_i(12'd1, 5'd0, 3'b000, 5'd5);
    mem[8] = enc_b(13'd6, 5'd2, 5'd1, 3'b001);
    mem[9] = enc_b(13'd6, 5'd2, 5'd1, 3'b000);
    reset_assert();
    reset_release();
    exp_q.push_back(32'd0);  exp_q.push_back(32'd4);  exp_q.push_back(32'd8);
    exp_q.push_back(32'd16); exp_q.push_back(32'd20); exp_q.push_back(32'd24);
    exp_q.push_back(32'd32); exp_q.push_back(32'd36);
    wait_halt(80, 1'b0, "br_halt");
    check("br_cause", halt_cause, 64'd3);
    check("br_retired", retired, 64'd7);
    check("br_pc_held", imem_addr, 64'd36);
    check_reg("br_x5", 5, 32'd0);
    check_reg("br_x6", 6, 32'd2);
    check("br_q_empty", 64'(exp_q.size()), 64'd0);

    // Test 5: ECALL, all-ones word and an unsupported funct7 all halt
    clear_mem();
    reset_assert();
    reset_release();
    push_fetch(1);
    wait_halt(20, 1'b0, "ecall_halt");
    check("ecall_cause", halt_cause, 64'd1);
    check("ecall_retired", retired, 64'd0);
    check_quiet("ecall_req_quiet");
    check("ecall_pc_held", imem_addr, 64'd0);
    mem[0] = 32'hFFFF_FFFF;
    reset_assert();
    reset_release();
    push_fetch(1);
    wait_halt(20, 1'b0, "ill_halt");
    check("ill_cause", halt_cause, 64'd2);
    check_quiet("ill_req_quiet");
    mem[0] = enc_i(12'd1, 5'd0, 3'b000, 5'd1);
    mem[1] = enc_r(7'h01, 5'd1, 5'd1, 3'b000, 5'd2);
    reset_assert();
    reset_release();
    push_fetch(2);
    wait_halt(30, 1'b0, "mul_halt");
    check("mul_cause", halt_cause, 64'd2);
    check("mul_retired", retired, 64'd1);
    check_reg("mul_x2", 2, 32'd0);

    // Test 6: reset while ADD x3 is in EXECUTE
    clear_mem();
    mem[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1);
    mem[1] = enc_i(12'hFFD, 5'd0, 3'b000, 5'd2);
    mem[2] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
    reset_assert();
    reset_release();
    push_fetch(3);
    repeat (10) @(negedge clk);
    check("abort_pre_retired", retired, 64'd2);
    check("abort_q_empty", 64'(exp_q.size()), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_retired", retired, 64'd0);
    check("abort_pc", imem_addr, 64'd0);
    check("abort_req", imem_req, 64'd0);
    check_reg("abort_x3", 3, 32'd0);
    check_reg("abort_x1", 1, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    clear_mem();
    exp_q.push_back(32'd0);
    wait_halt(20, 1'b0, "abort_restart_halt");

    // Test 6b: NREG=16 core rejects x17
    mem_b[0] = enc_i(12'd9, 5'd0, 3'b000, 5'd15);
    mem_b[1] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd17);
    check("rv32e_rst_addr", imem_addr_b, 64'h40);
    check("rv32e_rst_req", imem_req_b, 64'd0);
    @(negedge clk);
    rst_b = 1'b0;
    wait_halt(30, 1'b1, "rv32e_halt");
    check("rv32e_cause", halt_cause_b, 64'd2);
    check("rv32e_retired", retired_b, 64'd1);
    check("rv32e_pc", imem_addr_b, 64'h44);
    dbg_addr_b = 4'd15;
    #1;
    check("rv32e_x15", dbg_data_b, 64'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
